// File: rtl/mole_game_if.sv
// mole_game_if: control inputs and game status outputs
// of the whack-a-mole core.
interface mole_game_if;
  logic       start;
  logic       hit;
  logic [3:0] hit_pos;
  logic [8:0] mole_map;
  logic [7:0] score;
  logic [7:0] miss_cnt;
  logic [7:0] time_left;
  logic [1:0] game_state;
  logic       hit_ok;
  logic       hit_bad;

  modport master (
    output start, hit, hit_pos,
    input  mole_map, score, miss_cnt,
    input  time_left, game_state,
    input  hit_ok, hit_bad
  );

  modport slave (
    input  start, hit, hit_pos,
    output mole_map, score, miss_cnt,
    output time_left, game_state,
    output hit_ok, hit_bad
  );
endinterface

// File: rtl/mole_game_core.sv
// mole_game_core: whack-a-mole engine with tick timer,
// LFSR mole spawning, per-hole lifetimes and scoring.
module mole_game_core #(
  parameter int TICK_DIV   = 25_000_000,
  parameter int MOLE_LIFE  = 6,
  parameter int GAME_TICKS = 60,
  parameter int MAX_MOLES  = 3
) (
  input  logic       clk,
  input  logic       rst,
  mole_game_if.slave bus
);
  localparam int CW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [8:0]  map_q, map_d;
  logic [3:0]  life_q [9];
  logic [3:0]  life_d [9];
  logic [7:0]  score_q, score_d;
  logic [7:0]  miss_q, miss_d;
  logic [7:0]  time_q, time_d;
  logic        ok_q, ok_d;
  logic        bad_q, bad_d;

  logic        tick, last, hit_v, spawn;
  logic [3:0]  cand;
  logic [8:0]  hit_1h, cand_1h;
  logic [3:0]  miss_add;
  logic [9:0]  miss_sum;

  assign tick = (state_q == PLAY) &&
                (cnt_q == CW'(TICK_DIV - 1));
  assign last = tick && (time_q == 8'd1);
  assign hit_v = bus.hit && (state_q == PLAY) &&
                 (bus.hit_pos < 4'd9);
  assign hit_1h = hit_v ? (9'd1 << bus.hit_pos) : '0;
  assign cand = lfsr_q[3:0];
  assign cand_1h = (cand < 4'd9) ? (9'd1 << cand) : '0;

  // a hole being struck this cycle is not a spawn target
  assign spawn = tick && !last &&
                 (cand_1h != '0) &&
                 ((cand_1h & map_q) == '0) &&
                 !(bus.hit && bus.hit_pos == cand) &&
                 ($countones(map_q) < MAX_MOLES);

  assign lfsr_d = {lfsr_q[6:0],
                   lfsr_q[7] ^ lfsr_q[5] ^
                   lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, OVER: if (bus.start) state_d = PLAY;
      PLAY:       if (last) state_d = OVER;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    map_d    = map_q;
    life_d   = life_q;
    score_d  = score_q;
    miss_d   = miss_q;
    time_d   = time_q;
    cnt_d    = cnt_q;
    ok_d     = 1'b0;
    bad_d    = 1'b0;
    miss_add = '0;
    miss_sum = '0;
    if (state_q != PLAY) begin
      cnt_d = '0;
      if (bus.start) begin
        map_d   = '0;
        life_d  = '{default: 4'd0};
        score_d = '0;
        miss_d  = '0;
        time_d  = 8'(GAME_TICKS);
      end
    end else begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      ok_d  = |(hit_1h & map_q);
      bad_d = hit_v && !ok_d;
      map_d = map_q & ~hit_1h;
      for (int i = 0; i < 9; i++)
        if (hit_1h[i]) life_d[i] = '0;
      if (last) begin
        time_d = '0;
        map_d  = '0;
        life_d = '{default: 4'd0};
      end else if (tick) begin
        time_d = time_q - 8'd1;
        // a struck hole is removed by the hit, not by expiry
        for (int i = 0; i < 9; i++) begin
          if (map_q[i] && !hit_1h[i]) begin
            if (life_q[i] == 4'd1) begin
              map_d[i]  = 1'b0;
              life_d[i] = '0;
              miss_add  = miss_add + 4'd1;
            end else begin
              life_d[i] = life_q[i] - 4'd1;
            end
          end
        end
        for (int i = 0; i < 9; i++) begin
          if (spawn && cand_1h[i]) begin
            map_d[i]  = 1'b1;
            life_d[i] = 4'(MOLE_LIFE);
          end
        end
      end
      miss_add = miss_add + {3'd0, bad_d};
      miss_sum = {2'b00, miss_q} + {6'd0, miss_add};
      miss_d = (miss_sum > 10'd255) ? 8'hFF
                                    : miss_sum[7:0];
      if (ok_d && score_q != 8'hFF)
        score_d = score_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      lfsr_q  <= 8'hA5;
      map_q   <= '0;
      life_q  <= '{default: 4'd0};
      score_q <= '0;
      miss_q  <= '0;
      time_q  <= '0;
      ok_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      map_q   <= map_d;
      life_q  <= life_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      time_q  <= time_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
    end
  end

  assign bus.mole_map   = map_q;
  assign bus.score      = score_q;
  assign bus.miss_cnt   = miss_q;
  assign bus.time_left  = time_q;
  assign bus.game_state = state_q;
  assign bus.hit_ok     = ok_q;
  assign bus.hit_bad    = bad_q;
endmodule

// File: doc/mole_game_core.md
MOLE_GAME_CORE -- requirements
Module: mole_game_core

Interface
REQ-001 Parameter TICK_DIV, default 25_000_000, clk cycles per game tick (>=2).
REQ-002 Parameter MOLE_LIFE, default 6, ticks a mole stays up (1..15).
REQ-003 Parameter GAME_TICKS, default 60, game length in ticks (1..255).
REQ-004 Parameter MAX_MOLES, default 3, max simultaneous moles (1..9).
REQ-005 clk  in  1  single system clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset; asserted when 0.
REQ-007 start  in  1  level or pulse; begins a game from IDLE or OVER.
REQ-008 hit  in  1  key-press strobe, one cycle per press, from the keyboard interface.
REQ-009 hit_pos  in  4  hole index 0..8 qualified by hit; 15 = no key.
REQ-010 mole_map  out  9  bit i = mole up in hole i.
REQ-011 score  out  8  moles hit this game, saturating.
REQ-012 miss_cnt  out  8  moles expired unhit plus empty-hole hits, saturating.
REQ-013 time_left  out  8  ticks remaining in current game.
REQ-014 game_state  out  2  0=IDLE, 1=PLAY, 2=OVER.
REQ-015 hit_ok / hit_bad  out  1 each  one-cycle pulses, registered.

Function
REQ-016 FSM: IDLE -start-> PLAY; PLAY -last tick-> OVER; OVER -start-> PLAY; start SHALL be ignored in PLAY.
REQ-017 On entry to PLAY (cycle after start sampled): score=0, miss_cnt=0, mole_map=0, time_left=GAME_TICKS, tick counter=0.
REQ-018 Tick counter counts 0..TICK_DIV-1 only in PLAY; tick asserted the cycle it equals TICK_DIV-1, then wraps to 0.
REQ-019 On tick: time_left decrements; if time_left==1 before decrement, state -> OVER, mole_map cleared, no spawn/expiry that tick.
REQ-020 8-bit LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5, advances every cycle in all states.
REQ-021 Spawn on tick in PLAY: candidate c = lfsr[3:0]; spawn iff c<9, mole_map[c]==0, popcount(mole_map)<MAX_MOLES, and c != hit_pos of a hit in the same cycle; spawn sets bit c and loads life[c]=MOLE_LIFE.
REQ-022 Expiry on tick: each up hole with life>1 decrements; hole with life==1 clears bit, miss_cnt+1.
REQ-023 Hit in PLAY with hit_pos<9: mole_map[hit_pos]==1 -> clear bit, score+1, hit_ok pulse next cycle; else miss_cnt+1, hit_bad pulse next cycle.
REQ-024 Hit with hit_pos>=9, or hit outside PLAY: no effect, no pulse.
REQ-025 Hit and expiry on same hole, same cycle: hit wins (score+1, no miss).
REQ-026 Hit on empty hole and expiry elsewhere, same cycle: miss_cnt +2 (saturating).
REQ-027 score and miss_cnt saturate at 255, never wrap.
REQ-028 All outputs are registered; hit effects visible on outputs one cycle after hit sampled.
REQ-029 OVER holds score, miss_cnt, time_left=0 until next start.

Reset
REQ-030 rst=0 SHALL immediately force: game_state=IDLE, mole_map=0, score=0, miss_cnt=0, time_left=0, hit_ok=hit_bad=0, lfsr=8'hA5, tick counter=0, all life counters=0.
REQ-031 Reset mid-PLAY SHALL abandon the game; after release block waits in IDLE for start.
REQ-032 Release of rst is synchronous to clk by the integrator; block needs no extra release logic.

Verification (TICK_DIV=4, MOLE_LIFE=3, GAME_TICKS=10, MAX_MOLES=3)
REQ-033 Reset then start pulse -> game_state=1, time_left=10; after 40 cycles game_state=2, mole_map=0.
REQ-034 Force mole in hole 4 up, hit with hit_pos=4 -> next cycle bit 4 clear, score=1, hit_ok=1 for one cycle.
REQ-035 Hit hit_pos=2 with hole 2 empty -> miss_cnt+1, hit_bad pulse; hit_pos=15 -> no change.
REQ-036 Let mole go unhit -> cleared exactly 3 ticks after spawn, miss_cnt+1; hit on same cycle as expiry -> score+1, miss unchanged.
REQ-037 Run full game with no hits -> popcount(mole_map) never exceeds 3; score=0 in OVER; start again clears counters.
REQ-038 Assert rst=0 mid-PLAY between clock edges -> outputs reset without waiting for clk edge.
